spi_slave: RTL and testbench

SPI responder for the SPI master block: receives MSB-first 8-bit frames on MOSI and returns MSB-first bytes on MISO in all four CPOL/CPHA modes. A single CS-low window may carry any number of back-to-back bytes; the 40-bit master write arrives as five consecutive bytes. The block sits on the peripheral side of the link. It oversamples SCLK, MOSI and CS in the local clk domain, hands each received byte to local logic with a one-cycle strobe, and takes transmit bytes through a one-entry holding buffer.

---
 rtl/spi_slave.sv | 188 ++++++++++++++++++
 tb/tb_spi_slave.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI peripheral-side responder: oversamples SCLK/MOSI/CS in the clk domain,
// supports all four CPOL/CPHA modes, MSB-first bytes, one-entry transmit buffer.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] MODE,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       CS,
  output logic       MISO,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic sclk_s, mosi_s, cs_s;
  logic sclk_d, cs_d;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // CS chain resets to the deselected level so reset release never looks like a CS fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage take the previous stage's old value.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  logic cpol, cpha, first;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift, hold_buf;
  logic hold_full;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign cs_fall     = ~cs_s & cs_d;
  assign cs_rise     = cs_s & ~cs_d;
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  logic start, stop, do_sample, do_shift, do_hold, do_boundary;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d     = state_q;
    start       = 1'b0;
    stop        = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    do_hold     = 1'b0;
    do_boundary = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = SHIFT;
          start       = 1'b1;
          do_boundary = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else begin
          do_sample = sample_edge;
          // A shift edge at bit 0 is the byte boundary, except the very first
          // CPHA=1 leading edge whose bit was already presented at CS fall.
          if (shift_edge) begin
            if (bit_cnt != 3'd0) do_shift    = 1'b1;
            else if (first)      do_hold     = 1'b1;
            else                 do_boundary = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: data registers and the holding buffer are reset too, so a mid-frame reset
  // leaves no stale byte to be transmitted or reported afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpol        <= 1'b0;
      cpha        <= 1'b0;
      first       <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_shift    <= 7'd0;
      tx_shift    <= 8'd0;
      hold_buf    <= 8'd0;
      hold_full   <= 1'b0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;

      if (start) begin
        cpol     <= MODE[1];
        cpha     <= MODE[0];
        bit_cnt  <= 3'd0;
        first    <= 1'b1;
        rx_shift <= 7'd0;
      end

      if (stop) begin
        frame_err <= (bit_cnt != 3'd0);
        bit_cnt   <= 3'd0;
        first     <= 1'b0;
        rx_shift  <= 7'd0;
        tx_shift  <= 8'd0;
      end

      if (do_sample) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        first    <= 1'b0;
        if (bit_cnt == 3'd7) begin
          rx_data  <= {rx_shift, mosi_s};
          rx_valid <= 1'b1;
        end
      end

      if (do_hold)  first    <= 1'b0;
      if (do_shift) tx_shift <= {tx_shift[6:0], 1'b0};

      // A load coinciding with a boundary on an empty buffer bypasses straight to the shifter.
      if (do_boundary) begin
        if (hold_full) begin
          tx_shift  <= hold_buf;
          hold_full <= 1'b0;
        end else if (tx_load) begin
          tx_shift <= tx_data;
        end else begin
          tx_shift    <= 8'd0;
          tx_underrun <= 1'b1;
        end
      end else if (tx_load && !hold_full) begin
        hold_buf  <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign busy     = (state_q == SHIFT);
  assign miso_oe  = busy;
  assign MISO     = busy & tx_shift[7];
  assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged SPI master in all four modes,
// with pulse monitors for rx_valid, tx_underrun and frame_err.
module tb_spi_slave;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] MODE;
  logic       SCLK, MOSI, CS;
  logic       MISO, miso_oe;
  logic [7:0] tx_data;
  logic       tx_load, tx_ready, tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_err;

  int vectors     = 0;
  int miscompares = 0;
  int rx_cnt = 0, ur_cnt = 0, fe_cnt = 0;
  logic [7:0] rx_log[$];

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .MODE(MODE), .SCLK(SCLK), .MOSI(MOSI), .CS(CS),
    .MISO(MISO), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      rx_log.push_back(rx_data);
    end
    if (tx_underrun) ur_cnt <= ur_cnt + 1;
    if (frame_err)   fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // One CS window of nbits bits. refill[k] is loaded midway through byte k when refill_en[k].
  task automatic run_frame(input string tag, input logic [1:0] mode, input int nbits,
                           input logic [39:0] mosi_word, input logic [4:0] refill_en,
                           input logic [4:0][7:0] refill, input logic [39:0] exp_miso,
                           input int exp_ur, input int exp_fe);
    int rx0, ur0, fe0, unstable, nbytes;
    logic [39:0] miso_word;
    logic cpol, cpha, s;
    logic [7:0] got;
    rx0 = rx_cnt; ur0 = ur_cnt; fe0 = fe_cnt;
    unstable = 0; miso_word = '0;
    cpol = mode[1]; cpha = mode[0];
    MODE = mode; SCLK = cpol;
    wait_clk(HALF);
    CS = 1'b0;
    if (cpha) wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        MOSI = mosi_word[nbits-1-i];
        wait_clk(HALF);
        SCLK = ~cpol;
        s = MISO;
        wait_clk(HALF);
        if (MISO !== s) unstable++;
        SCLK = cpol;
      end else begin
        SCLK = ~cpol;
        MOSI = mosi_word[nbits-1-i];
        wait_clk(HALF);
        SCLK = cpol;
        s = MISO;
        wait_clk(HALF);
        if (MISO !== s) unstable++;
      end
      miso_word = {miso_word[38:0], s};
      if (i == 0) begin
        check({tag, " busy_mid"}, busy, 1'b1);
        check({tag, " oe_mid"}, miso_oe, 1'b1);
      end
      if ((i % 8) == 3 && refill_en[i/8]) begin
        check({tag, " tx_ready_refill"}, tx_ready, 1'b1);
        load_byte(refill[i/8]);
      end
    end
    wait_clk(HALF);
    CS = 1'b1;
    wait_clk(HALF);
    nbytes = nbits / 8;
    check({tag, " miso_bytes"}, miso_word, exp_miso);
    check({tag, " miso_stable"}, unstable, 0);
    check({tag, " rx_count"}, rx_cnt - rx0, nbytes);
    for (int k = 0; k < nbytes; k++) begin
      got = (rx0 + k < rx_log.size()) ? rx_log[rx0+k] : 8'hxx;
      check({tag, " rx_byte"}, got, mosi_word[8*(nbytes-1-k) +: 8]);
    end
    check({tag, " underruns"}, ur_cnt - ur0, exp_ur);
    check({tag, " frame_errs"}, fe_cnt - fe0, exp_fe);
    check({tag, " busy_after"}, busy, 1'b0);
    check({tag, " oe_after"}, miso_oe, 1'b0);
  endtask

  initial begin
    int fe0;
    reset = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    MODE = 2'b00; tx_data = 8'h00; tx_load = 1'b0;
    wait_clk(3);
    check("rst MISO", MISO, 1'b0);
    check("rst miso_oe", miso_oe, 1'b0);
    check("rst tx_ready", tx_ready, 1'b1);
    check("rst tx_underrun", tx_underrun, 1'b0);
    check("rst rx_data", rx_data, 8'h00);
    check("rst rx_valid", rx_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst frame_err", frame_err, 1'b0);
    reset = 1'b1;
    wait_clk(5);

    // Mode 0 single byte; filler keeps the end-of-byte boundary from underrunning.
    load_byte(8'h3C);
    check("m0 tx_ready_full", tx_ready, 1'b0);
    run_frame("m0", 2'b00, 8, 40'hA5, 5'b00001, {32'h0, 8'hEE}, 40'h3C, 0, 0);

    // Mode 3 five-byte frame with refills 02..05.
    load_byte(8'h01);
    run_frame("m3", 2'b11, 40, 40'h12_34_56_78_9A, 5'b01111,
              {8'h00, 8'h05, 8'h04, 8'h03, 8'h02}, 40'h01_02_03_04_05, 0, 0);

    load_byte(8'h5A);
    run_frame("m1", 2'b01, 8, 40'hC3, 5'b00000, 40'h0, 40'h5A, 0, 0);
    load_byte(8'h5A);
    run_frame("m2", 2'b10, 8, 40'hC3, 5'b00001, {32'h0, 8'hEE}, 40'h5A, 0, 0);

    // Empty buffer at the second boundary: second byte returns 00.
    load_byte(8'h77);
    run_frame("underrun", 2'b01, 16, 40'h1122, 5'b00000, 40'h0, 40'h7700, 1, 0);

    // CS raised after 3 bits, then a clean frame.
    load_byte(8'hAB);
    run_frame("partial", 2'b00, 3, 40'h5, 5'b00000, 40'h0, 40'h5, 0, 1);
    load_byte(8'h0F);
    run_frame("after_err", 2'b00, 8, 40'hFF, 5'b00001, {32'h0, 8'hEE}, 40'h0F, 0, 0);
    check("after_err rx_data", rx_data, 8'hFF);

    // Reset in the middle of a byte with the holding buffer full.
    fe0 = fe_cnt;
    load_byte(8'h44);
    MODE = 2'b00;
    wait_clk(5);
    CS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MOSI = (i == 0);
      wait_clk(HALF);
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
    end
    load_byte(8'h99);
    wait_clk(2);
    check("pre_rst busy", busy, 1'b1);
    check("pre_rst tx_ready", tx_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst busy", busy, 1'b0);
    check("mid_rst miso_oe", miso_oe, 1'b0);
    check("mid_rst MISO", MISO, 1'b0);
    check("mid_rst tx_ready", tx_ready, 1'b1);
    check("mid_rst rx_data", rx_data, 8'h00);
    CS = 1'b1;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(10);
    check("post_rst frame_errs", fe_cnt - fe0, 0);
    load_byte(8'h24);
    run_frame("rst_recover", 2'b00, 8, 40'h81, 5'b00001, {32'h0, 8'hEE}, 40'h24, 0, 0);
    check("rst_recover rx_data", rx_data, 8'h81);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
